// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
module hilo_muldiv_unit #(
    parameter int              WIDTH      = 32,
    parameter logic [WIDTH-1:0] HILO_RESET = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t state, state_nx;

    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   divisor;

    logic               accept;
    logic               last_iter;
    logic               early_out;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [WIDTH:0]     partial;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign accept    = (state == IDLE) && start;
    assign last_iter = (count == CW'(WIDTH - 1));
    assign busy      = (state != IDLE);

    // op[0]=0 selects the signed variants; they work on magnitudes and fix signs at the end
    assign rs_mag = (!op[0] && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign rt_mag = (!op[0] && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    assign partial = {rem, quo[WIDTH-1]};
    assign diff    = partial - {1'b0, divisor};

    assign prod    = neg_q ? -acc : acc;
    assign quo_fix = neg_q ? -quo : quo;
    assign rem_fix = neg_r ? -rem : rem;

`ifdef MULDIV_EARLY_OUT_EN
    assign early_out = !is_div && (mplier == '0);
`else
    assign early_out = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (early_out || last_iter) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count   <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
        end else if (accept) begin
            count   <= '0;
            is_div  <= op[1];
            neg_q   <= !op[0] && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            neg_r   <= !op[0] && rs_val[WIDTH-1];
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, rs_mag};
            mplier  <= rt_mag;
            quo     <= rs_mag;
            rem     <= '0;
            divisor <= rt_mag;
        end else if (state == RUN) begin
            count <= count + 1'b1;
            if (is_div) begin
                // restoring step: the dividend shifts out of quo while quotient bits shift in
                if (!diff[WIDTH]) begin
                    rem <= diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= partial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi   <= HILO_RESET;
            lo   <= HILO_RESET;
            done <= 1'b0;
        end else begin
            done <= (state == FINISH);
            if (state == FINISH) begin
                if (is_div) begin
                    // divide by zero leaves all-ones quotient; rem_fix restores the original dividend
                    lo <= (divisor == '0) ? '1 : quo_fix;
                    hi <= rem_fix;
                end else begin
                    hi <= prod[2*WIDTH-1:WIDTH];
                    lo <= prod[WIDTH-1:0];
                end
            end else if (state == IDLE) begin
                if (mthi) hi <= rs_val;
                if (mtlo) lo <= rs_val;
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed cases plus randomized traffic
// against an arithmetic reference model.
module tb_hilo_muldiv_unit;

    localparam int W = 32;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    hilo_muldiv_unit #(.WIDTH(W), .HILO_RESET('0)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Architectural result as {HI, LO}, straight from integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, sq, sm;
        logic [63:0] ua, ub, uq, um, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: r = sa * sb;
            2'b01: r = ua * ub;
            2'b10: begin
                if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                else begin
                    sq = sa / sb;
                    sm = sa % sb;
                    r  = {sm[31:0], sq[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                else begin
                    uq = ua / ub;
                    um = ua % ub;
                    r  = {um[31:0], uq[31:0]};
                end
            end
        endcase
        return r;
    endfunction

    // Edges from the start edge to the HI/LO write.
    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] b);
        logic [31:0] mag;
        mag = (!o[0] && b[31]) ? -b : b;
        if (EARLY && !o[1]) begin
            if (mag == 32'd0) return 2;
            for (int i = 31; i >= 0; i--)
                if (mag[i]) return (i + 3 > 33) ? 33 : i + 3;
        end
        return 33;
    endfunction

    logic [31:0] m_hi, m_lo, r_hi, r_lo;
    logic        m_busy, m_done;
    int          m_left;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_hi   <= '0;
            m_lo   <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_hi   <= r_hi;
                    m_lo   <= r_lo;
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
                m_left <= m_left - 1;
            end else begin
                if (mthi) m_hi <= rs_val;
                if (mtlo) m_lo <= rs_val;
                if (start) begin
                    {r_hi, r_lo} <= ref_result(op, rs_val, rt_val);
                    m_left       <= ref_latency(op, rt_val);
                    m_busy       <= 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("busy", busy, m_busy);
            check("done", done, m_done);
        end
    end

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                lat = i + 1;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int elat);
        int lat;
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(negedge clock);
        start = 1'b0;
        wait_done(lat);
        check({name, "_lat"}, lat, elat);
        check({name, "_hi"}, hi, eh);
        check({name, "_lo"}, lo, el);
        check({name, "_model_hi"}, m_hi, eh);
        check({name, "_model_lo"}, m_lo, el);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'h80000000;
            3:       return 32'hFFFFFFFF;
            4:       return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        #3 reset = 1'b1;
        #1 chk_en = 1'b1;
        check("reset_hi", hi, 64'd0);
        check("reset_lo", lo, 64'd0);
        check("reset_busy", busy, 64'd0);
        check("reset_done", done, 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
        run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, EARLY ? 5 : 33);
        run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        run_op("div_zero", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 33);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33);
        run_op("mult_x0", 2'b00, 32'd1234, 32'd0, 32'd0, 32'd0, EARLY ? 2 : 33);
        run_op("mult_x1", 2'b00, 32'd5, 32'd1, 32'd0, 32'd5, EARLY ? 3 : 33);

        // start and mthi pulsed mid-operation must be ignored
        start  = 1'b1;
        op     = 2'b11;
        rs_val = 32'd100;
        rt_val = 32'd7;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        start  = 1'b1;
        mthi   = 1'b1;
        op     = 2'b00;
        rs_val = 32'hDEAD;
        rt_val = 32'd3;
        @(negedge clock);
        start = 1'b0;
        mthi  = 1'b0;
        wait_done(lat);
        check("disturb_hi", hi, 64'd2);
        check("disturb_lo", lo, 64'd14);

        mthi   = 1'b1;
        rs_val = 32'h1234;
        @(negedge clock);
        mthi = 1'b0;
        check("mthi_idle", hi, 64'h1234);

        // asynchronous reset in the middle of a divide
        start  = 1'b1;
        op     = 2'b11;
        rs_val = 32'd1000;
        rt_val = 32'd3;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (10) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check("abort_hi", hi, 64'd0);
        check("abort_lo", lo, 64'd0);
        check("abort_busy", busy, 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        run_op("multu_after_reset", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, EARLY ? 5 : 33);

        for (int c = 0; c < 1500; c++) begin
            start  = ($urandom_range(0, 2) == 0);
            op     = 2'($urandom_range(0, 3));
            rs_val = rnd_operand();
            rt_val = rnd_operand();
            mthi   = ($urandom_range(0, 7) == 0);
            mtlo   = ($urandom_range(0, 7) == 0);
            @(negedge clock);
        end
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        for (int i = 0; i < 40 && m_busy; i++) @(negedge clock);
        @(negedge clock);
        check("drained_busy", busy, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the control decode, beside the main ALU. It serves MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO. It raises busy so the PC stage can stall while an operation is in flight.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH
HILO_RESET, 0, value loaded into HI and LO on reset

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request a mul/div; sampled on a rising edge only when busy=0
op  input  2  2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU
rs_val  input  WIDTH  multiplicand / dividend
rt_val  input  WIDTH  multiplier / divisor
mthi  input  1  write rs_val to HI
mtlo  input  1  write rs_val to LO
hi  output  WIDTH  current HI register (MFHI source)
lo  output  WIDTH  current LO register (MFLO source)
busy  output  1  operation in flight; upstream must stall
done  output  1  one-cycle pulse in the cycle after HI/LO are written

Behaviour:
- Reset (asynchronous, active-high): hi=lo=HILO_RESET, busy=0, done=0, state=IDLE.
- Reset mid-operation aborts the operation; no partial result reaches HI/LO.
- States: IDLE, RUN, FINISH.
- IDLE, edge E0 with start=1: latch operands, op and sign flags; count=0; ->RUN; busy=1 from E0.
- Operand latching: signed ops latch operand magnitudes. MULTU/DIVU treat operands as unsigned.
- RUN, multiply: radix-2 shift-add, one multiplier bit per edge, 2*WIDTH-bit accumulator.
- RUN, divide: restoring shift-subtract, one quotient bit per edge.
- RUN exit: after WIDTH iterations (edges E1..E32 for WIDTH=32), ->FINISH.
- FINISH, edge E33: apply sign correction and write HI/LO; ->IDLE; busy=0 and done=1 after E33; done=0 after E34.
- Fixed latency: 33 edges from the start edge to the HI/LO update.
- MULT/MULTU result: {HI,LO} = full 2*WIDTH-bit product. MULT negates the product if the operand signs differ.
- DIV/DIVU result: LO=quotient, HI=remainder.
- Signed DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (rt_val=0, either signedness): LO=all ones, HI=dividend as latched. No exception is raised.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- start while busy=1: ignored; no queuing.
- mthi/mtlo while busy=0: write HI/LO at that edge.
- mthi/mtlo while busy=1: ignored.
- mthi/mtlo together with start in IDLE: the moves apply at E0; the operation result overwrites HI/LO at E33.
- hi/lo outputs are registered and hold their old values throughout RUN.
- A new start is accepted on the same edge where done is high (back-to-back operations allowed).

Optional Feature:
Macro MULDIV_EARLY_OUT_EN.
- Defined: for MULT/MULTU only, at each RUN edge, if the remaining multiplier bits are all zero, go to FINISH instead of iterating.
  - Multiply by 0: FINISH write at E2.
  - Multiply by 1: FINISH write at E3.
  - Divides keep the fixed 33-edge latency.
- Undefined: every operation takes exactly 33 edges. No early-out logic is synthesised.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> at E33: HI=0xFFFFFFFE, LO=0x00000001; busy high E0..E33; one done pulse.
- MULT 0xFFFFFFFD (-3) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIVU 100/7 -> LO=14, HI=2.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 5/0 -> LO=0xFFFFFFFF, HI=5.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- start and mthi pulsed during RUN -> both ignored; result as for an undisturbed operation. Then mthi with rs_val=0x1234 while idle -> hi=0x1234 next cycle.
- Reset asserted asynchronously at E10 of a DIVU -> hi=lo=0, busy=0 immediately.
  - A new MULTU 3x4 after release -> LO=12, HI=0.
  - With MULDIV_EARLY_OUT_EN defined: MULT by 0 -> done after E2; MULT by 1 -> done after E3.
